// File: rtl/elbeth_pipeline_ctrl_pkg.sv
// Shared encodings for the elbeth pipeline controller: forward selects,
// controller state codes and the operand-source selection rule.
package elbeth_pipeline_ctrl_pkg;

  typedef logic [1:0] fwdSel_t;

  localparam fwdSel_t    FWD_GPR = 2'b00;
  localparam fwdSel_t    FWD_ALU = 2'b01;
  localparam fwdSel_t    FWD_MEM = 2'b10;

  localparam logic [1:0] CTRL_RUN      = 2'b00;
  localparam logic [1:0] CTRL_MEM_WAIT = 2'b01;
  localparam logic [1:0] CTRL_FLUSH    = 2'b10;

  localparam logic [4:0] RD_ZERO = 5'd0;

  // An ALU result is usable as soon as it exists; a load result only in the
  // cycle the data memory delivers it.
  function automatic fwdSel_t selectFwd(input logic match, input logic memEn,
                                        input logic isLoad, input logic ready);
    if (match && !memEn)
      return FWD_ALU;
    else if (match && isLoad && ready)
      return FWD_MEM;
    else
      return FWD_GPR;
  endfunction

endpackage

// File: rtl/elbeth_pipeline_ctrl_if.sv
// Control bus between the IF/ID/EXS datapath and the pipeline sequencer.
interface elbeth_pipeline_ctrl_if;
  import elbeth_pipeline_ctrl_pkg::*;

  logic [4:0] idRs1;
  logic [4:0] idRs2;
  logic [4:0] exsRdAddr;
  logic       exsWGprEn;
  logic       exsMemEn;
  logic       exsMemWr;
  logic       dmemReady;
  logic       exsBranchTaken;

  logic       ifStall;
  logic       idStall;
  logic       exsStall;
  logic       ifFlush;
  logic       idFlush;
  logic       exsFlush;
  fwdSel_t    fwdSelRs1;
  fwdSel_t    fwdSelRs2;
  logic       memTimeoutErr;

  modport master (
    output idRs1, idRs2, exsRdAddr, exsWGprEn, exsMemEn, exsMemWr,
           dmemReady, exsBranchTaken,
    input  ifStall, idStall, exsStall, ifFlush, idFlush, exsFlush,
           fwdSelRs1, fwdSelRs2, memTimeoutErr
  );

  modport slave (
    input  idRs1, idRs2, exsRdAddr, exsWGprEn, exsMemEn, exsMemWr,
           dmemReady, exsBranchTaken,
    output ifStall, idStall, exsStall, ifFlush, idFlush, exsFlush,
           fwdSelRs1, fwdSelRs2, memTimeoutErr
  );

endinterface

// File: rtl/elbeth_pipeline_ctrl_hazard_unit.sv
// RAW match detection between the ID source operands and the EXS destination.
module elbeth_hazard_unit
  import elbeth_pipeline_ctrl_pkg::*;
(
  input  logic [4:0] i_idRs1,
  input  logic [4:0] i_idRs2,
  input  logic [4:0] i_exsRdAddr,
  input  logic       i_exsWGprEn,
  output logic       o_matchRs1,
  output logic       o_matchRs2
);

  // x0 is hard-wired to zero, so a write to it never produces a hazard.
  logic w_rdValid;
  assign w_rdValid  = i_exsWGprEn && (i_exsRdAddr != RD_ZERO);

  assign o_matchRs1 = w_rdValid && (i_idRs1 == i_exsRdAddr);
  assign o_matchRs2 = w_rdValid && (i_idRs2 == i_exsRdAddr);

endmodule

// File: rtl/elbeth_pipeline_ctrl.sv
// Pipeline sequencer: stalls on data-memory waits, flushes IF/ID after taken
// branches, aborts hung accesses via a watchdog and drives forward selects.
module elbeth_pipeline_ctrl
  import elbeth_pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  elbeth_pipeline_ctrl_if.slave io_bus
);

  logic             w_matchRs1;
  logic             w_matchRs2;
  logic             w_memStall;
  logic             w_isLoad;
  logic             w_branch;

  logic [1:0]       r_state;
  logic [3:0]       r_flushCnt;
  logic [CNT_W-1:0] r_watchdog;
  logic             r_branchPending;

  logic [1:0]       w_nextState;
  logic [3:0]       w_nextFlushCnt;
  logic [CNT_W-1:0] w_nextWatchdog;
  logic             w_nextPending;
  logic             w_stallAll;
  logic             w_flushIfId;
  logic             w_flushExs;
  logic             w_timeoutErr;

  elbeth_hazard_unit u_hazard (
    .i_idRs1     (io_bus.idRs1),
    .i_idRs2     (io_bus.idRs2),
    .i_exsRdAddr (io_bus.exsRdAddr),
    .i_exsWGprEn (io_bus.exsWGprEn),
    .o_matchRs1  (w_matchRs1),
    .o_matchRs2  (w_matchRs2)
  );

  assign w_memStall = io_bus.exsMemEn && !io_bus.dmemReady;
  assign w_isLoad   = io_bus.exsMemEn && !io_bus.exsMemWr;
  // A branch seen while stalled is remembered and acted on once the stall lifts.
  assign w_branch   = io_bus.exsBranchTaken || r_branchPending;

  always_comb begin
    w_nextState    = r_state;
    w_nextFlushCnt = r_flushCnt;
    w_nextWatchdog = r_watchdog;
    w_nextPending  = r_branchPending;
    w_stallAll     = 1'b0;
    w_flushIfId    = 1'b0;
    w_flushExs     = 1'b0;
    w_timeoutErr   = 1'b0;
    case (r_state)
      CTRL_RUN: begin
        if (w_memStall) begin
          w_stallAll     = 1'b1;
          w_nextState    = CTRL_MEM_WAIT;
          w_nextWatchdog = CNT_W'(1);
          w_nextPending  = r_branchPending || io_bus.exsBranchTaken;
        end else if (w_branch) begin
          w_flushIfId    = 1'b1;
          w_nextState    = CTRL_FLUSH;
          w_nextFlushCnt = 4'(FLUSH_CYCLES);
          w_nextPending  = 1'b0;
        end
      end
      CTRL_MEM_WAIT: begin
        if (io_bus.dmemReady) begin
          w_nextWatchdog = '0;
          if (w_branch) begin
            w_flushIfId    = 1'b1;
            w_nextState    = CTRL_FLUSH;
            w_nextFlushCnt = 4'(FLUSH_CYCLES);
            w_nextPending  = 1'b0;
          end else begin
            w_nextState    = CTRL_RUN;
          end
        end else if (r_watchdog == CNT_W'(MEM_TIMEOUT)) begin
          w_flushExs     = 1'b1;
          w_timeoutErr   = 1'b1;
          w_nextState    = CTRL_RUN;
          w_nextWatchdog = '0;
          w_nextPending  = 1'b0;
        end else begin
          w_stallAll     = 1'b1;
          w_nextWatchdog = r_watchdog + CNT_W'(1);
          w_nextPending  = r_branchPending || io_bus.exsBranchTaken;
        end
      end
      CTRL_FLUSH: begin
        if (w_memStall) begin
          w_stallAll     = 1'b1;
          w_nextPending  = r_branchPending || io_bus.exsBranchTaken;
        end else if (w_branch) begin
          w_flushIfId    = 1'b1;
          w_nextFlushCnt = 4'(FLUSH_CYCLES);
          w_nextPending  = 1'b0;
        end else if (r_flushCnt != 4'd0) begin
          w_flushIfId    = 1'b1;
          w_nextFlushCnt = r_flushCnt - 4'd1;
          if (r_flushCnt == 4'd1)
            w_nextState  = CTRL_RUN;
        end else begin
          w_nextState    = CTRL_RUN;
        end
      end
      default: begin
        w_nextState    = CTRL_RUN;
        w_nextFlushCnt = 4'd0;
        w_nextWatchdog = '0;
        w_nextPending  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= CTRL_RUN;
      r_flushCnt      <= 4'd0;
      r_watchdog      <= '0;
      r_branchPending <= 1'b0;
    end else begin
      r_state         <= w_nextState;
      r_flushCnt      <= w_nextFlushCnt;
      r_watchdog      <= w_nextWatchdog;
      r_branchPending <= w_nextPending;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign io_bus.ifStall       = !rst && w_stallAll;
  assign io_bus.idStall       = !rst && w_stallAll;
  assign io_bus.exsStall      = !rst && w_stallAll;
  assign io_bus.ifFlush       = !rst && w_flushIfId;
  assign io_bus.idFlush       = !rst && w_flushIfId;
  assign io_bus.exsFlush      = !rst && w_flushExs;
  assign io_bus.memTimeoutErr = !rst && w_timeoutErr;
  assign io_bus.fwdSelRs1     = rst ? FWD_GPR :
      selectFwd(w_matchRs1, io_bus.exsMemEn, w_isLoad, io_bus.dmemReady);
  assign io_bus.fwdSelRs2     = rst ? FWD_GPR :
      selectFwd(w_matchRs2, io_bus.exsMemEn, w_isLoad, io_bus.dmemReady);

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// Directed scoreboard bench for elbeth_pipeline_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_elbeth_pipeline_ctrl;
  import elbeth_pipeline_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wgpr;
    logic       memEn;
    logic       memWr;
    logic       ready;
    logic       br;
  } in_t;

  typedef struct packed {
    logic    ifStall;
    logic    idStall;
    logic    exsStall;
    logic    ifFlush;
    logic    idFlush;
    logic    exsFlush;
    fwdSel_t fwd1;
    fwdSel_t fwd2;
    logic    err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecCount  = 0;
  int   missCount = 0;
  exp_t  expQ[$];
  string nameQ[$];

  elbeth_pipeline_ctrl_if bus ();

  elbeth_pipeline_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .CNT_W        (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic in_t mkIn(input int rs1, input int rs2, input int rd,
                               input logic wgpr, input logic memEn,
                               input logic memWr, input logic ready,
                               input logic br);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.wgpr = wgpr; v.memEn = memEn; v.memWr = memWr; v.ready = ready; v.br = br;
    return v;
  endfunction

  function automatic exp_t mkExp(input logic stall, input logic flushIfId,
                                 input logic flushExs, input fwdSel_t f1,
                                 input fwdSel_t f2, input logic err);
    exp_t e;
    e.ifStall = stall; e.idStall = stall; e.exsStall = stall;
    e.ifFlush = flushIfId; e.idFlush = flushIfId; e.exsFlush = flushExs;
    e.fwd1 = f1; e.fwd2 = f2; e.err = err;
    return e;
  endfunction

  task automatic applyStimulus(input string name, input in_t v,
                               input logic rstIn, input exp_t e);
    @(posedge clk);
    #1;
    rst                = rstIn;
    bus.idRs1          = v.rs1;
    bus.idRs2          = v.rs2;
    bus.exsRdAddr      = v.rd;
    bus.exsWGprEn      = v.wgpr;
    bus.exsMemEn       = v.memEn;
    bus.exsMemWr       = v.memWr;
    bus.dmemReady      = v.ready;
    bus.exsBranchTaken = v.br;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = {bus.ifStall, bus.idStall, bus.exsStall, bus.ifFlush, bus.idFlush,
           bus.exsFlush, bus.fwdSelRs1, bus.fwdSelRs2, bus.memTimeoutErr};
    vecCount++;
    if (act !== e) begin
      missCount++;
      $display("[TB] FAIL %s: got stl=%b%b%b fl=%b%b%b f1=%b f2=%b err=%b, need stl=%b%b%b fl=%b%b%b f1=%b f2=%b err=%b",
               name, act.ifStall, act.idStall, act.exsStall, act.ifFlush,
               act.idFlush, act.exsFlush, act.fwd1, act.fwd2, act.err,
               e.ifStall, e.idStall, e.exsStall, e.ifFlush, e.idFlush,
               e.exsFlush, e.fwd1, e.fwd2, e.err);
    end
  endtask

  // Monitor: compares each presented output cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  initial begin
    in_t  idle;
    exp_t quiet;
    exp_t stl;
    exp_t fl;
    idle  = mkIn(1, 2, 0, 0, 0, 0, 0, 0);
    quiet = mkExp(0, 0, 0, FWD_GPR, FWD_GPR, 0);
    stl   = mkExp(1, 0, 0, FWD_GPR, FWD_GPR, 0);
    fl    = mkExp(0, 1, 0, FWD_GPR, FWD_GPR, 0);

    bus.idRs1 = '0; bus.idRs2 = '0; bus.exsRdAddr = '0; bus.exsWGprEn = 1'b0;
    bus.exsMemEn = 1'b0; bus.exsMemWr = 1'b0; bus.dmemReady = 1'b0;
    bus.exsBranchTaken = 1'b0;

    applyStimulus("reset_held", mkIn(5, 5, 5, 1, 0, 0, 0, 1), 1'b1, quiet);
    applyStimulus("reset_release", idle, 1'b0, quiet);

    applyStimulus("alu_raw_rs1", mkIn(5, 3, 5, 1, 0, 0, 0, 0), 1'b0,
                  mkExp(0, 0, 0, FWD_ALU, FWD_GPR, 0));
    applyStimulus("alu_raw_both", mkIn(5, 5, 5, 1, 0, 0, 0, 0), 1'b0,
                  mkExp(0, 0, 0, FWD_ALU, FWD_ALU, 0));
    applyStimulus("alu_rd_x0", mkIn(0, 0, 0, 1, 0, 0, 0, 0), 1'b0, quiet);
    applyStimulus("alu_no_wen", mkIn(5, 5, 5, 0, 0, 0, 0, 0), 1'b0, quiet);

    applyStimulus("load_use_w1", mkIn(1, 7, 7, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("load_use_w2", mkIn(1, 7, 7, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("load_use_done", mkIn(1, 7, 7, 1, 1, 0, 1, 0), 1'b0,
                  mkExp(0, 0, 0, FWD_GPR, FWD_MEM, 0));
    applyStimulus("load_x0_w1", mkIn(0, 0, 0, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("load_x0_w2", mkIn(0, 0, 0, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("load_x0_done", mkIn(0, 0, 0, 1, 1, 0, 1, 0), 1'b0, quiet);
    applyStimulus("load_1cycle", mkIn(7, 2, 7, 1, 1, 0, 1, 0), 1'b0,
                  mkExp(0, 0, 0, FWD_MEM, FWD_GPR, 0));
    applyStimulus("store_1cycle", mkIn(7, 2, 7, 0, 1, 1, 1, 0), 1'b0, quiet);

    applyStimulus("branch_pulse", mkIn(1, 2, 0, 0, 0, 0, 0, 1), 1'b0, fl);
    applyStimulus("branch_fl1", idle, 1'b0, fl);
    applyStimulus("branch_fl2", idle, 1'b0, fl);
    applyStimulus("branch_run", idle, 1'b0, quiet);

    applyStimulus("reload_pulse", mkIn(1, 2, 0, 0, 0, 0, 0, 1), 1'b0, fl);
    applyStimulus("reload_fl1", idle, 1'b0, fl);
    applyStimulus("reload_again", mkIn(1, 2, 0, 0, 0, 0, 0, 1), 1'b0, fl);
    applyStimulus("reload_fl2", idle, 1'b0, fl);
    applyStimulus("reload_fl3", idle, 1'b0, fl);
    applyStimulus("reload_run", idle, 1'b0, quiet);

    applyStimulus("flmem_pulse", mkIn(1, 2, 0, 0, 0, 0, 0, 1), 1'b0, fl);
    applyStimulus("flmem_stall", mkIn(1, 2, 0, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("flmem_resume", mkIn(1, 2, 0, 1, 1, 0, 1, 0), 1'b0, fl);
    applyStimulus("flmem_last", idle, 1'b0, fl);
    applyStimulus("flmem_run", idle, 1'b0, quiet);

    applyStimulus("defer_both", mkIn(1, 2, 0, 1, 1, 0, 0, 1), 1'b0, stl);
    applyStimulus("defer_wait", mkIn(1, 2, 0, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("defer_release", mkIn(1, 2, 0, 1, 1, 0, 1, 0), 1'b0, fl);
    applyStimulus("defer_fl1", idle, 1'b0, fl);
    applyStimulus("defer_fl2", idle, 1'b0, fl);
    applyStimulus("defer_run", idle, 1'b0, quiet);

    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("timeout_wait%0d", i), mkIn(1, 2, 0, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("timeout_abort", mkIn(1, 2, 0, 1, 1, 0, 0, 0), 1'b0,
                  mkExp(0, 0, 1, FWD_GPR, FWD_GPR, 1));
    applyStimulus("timeout_run", mkIn(1, 2, 0, 0, 0, 0, 0, 0), 1'b0, quiet);

    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("edge_wait%0d", i), mkIn(7, 2, 7, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("edge_ready_wins", mkIn(7, 2, 7, 1, 1, 0, 1, 0), 1'b0,
                  mkExp(0, 0, 0, FWD_MEM, FWD_GPR, 0));
    applyStimulus("edge_run", idle, 1'b0, quiet);

    applyStimulus("rstmw_w1", mkIn(7, 2, 7, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("rstmw_w2", mkIn(7, 2, 7, 1, 1, 0, 0, 0), 1'b0, stl);
    applyStimulus("rstmw_assert", mkIn(7, 7, 7, 1, 1, 0, 1, 1), 1'b1, quiet);
    applyStimulus("rstmw_release", idle, 1'b0, quiet);

    applyStimulus("rstfl_pulse", mkIn(1, 2, 0, 0, 0, 0, 0, 1), 1'b0, fl);
    applyStimulus("rstfl_assert", idle, 1'b1, quiet);
    applyStimulus("rstfl_release", idle, 1'b0, quiet);
    applyStimulus("rstfl_alu", mkIn(3, 3, 3, 1, 0, 0, 0, 0), 1'b0,
                  mkExp(0, 0, 0, FWD_ALU, FWD_ALU, 0));

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d expectations left, need 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
